// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encoding for the monitor UART
package uart_pkg;

   // Transmitter FSM state encoding
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   // Default frame shape: 8 data bits, 1 stop bit
   localparam int DEF_DATA_BITS = 8;
   localparam int DEF_STOP_BITS = 1;

   // Clock cycles per bit period produced by uart_timer
   localparam int BIT_PERIOD = 227;

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with one-byte holding register
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = DEF_STOP_BITS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_vld,
   output logic       tx_rdy,
   output logic       uart_tm_en,
   input  logic       uart_tm_ov,
   output logic       txd,
   output logic       tx_busy
);

   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

   uart_state_t state, state_nxt;
   logic [7:0]  hold, hold_nxt;
   logic        hold_full, hold_full_nxt;
   logic [7:0]  shift, shift_nxt;
   logic [2:0]  bit_cnt, bit_cnt_nxt;
   logic        stop_cnt, stop_cnt_nxt;
   logic        parity, parity_nxt;
   logic        txd_nxt, tm_en_nxt, busy_nxt;
   logic        do_load;

   // The producer may write whenever the holding register is empty
   assign tx_rdy = ~hold_full;

   // State and registered outputs; reset aborts any frame and drops the buffered byte
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         hold       <= 8'h00;
         hold_full  <= 1'b0;
         shift      <= 8'h00;
         bit_cnt    <= 3'd0;
         stop_cnt   <= 1'b0;
         parity     <= 1'b0;
         txd        <= 1'b1;
         uart_tm_en <= 1'b0;
         tx_busy    <= 1'b0;
      end else begin
         state      <= state_nxt;
         hold       <= hold_nxt;
         hold_full  <= hold_full_nxt;
         shift      <= shift_nxt;
         bit_cnt    <= bit_cnt_nxt;
         stop_cnt   <= stop_cnt_nxt;
         parity     <= parity_nxt;
         txd        <= txd_nxt;
         uart_tm_en <= tm_en_nxt;
         tx_busy    <= busy_nxt;
      end
   end

   // Next-state logic: accept into hold, advance one bit per timer overflow
   always_comb begin
      state_nxt     = state;
      hold_nxt      = hold;
      hold_full_nxt = hold_full;
      shift_nxt     = shift;
      bit_cnt_nxt   = bit_cnt;
      stop_cnt_nxt  = stop_cnt;
      parity_nxt    = parity;
      txd_nxt       = txd;
      tm_en_nxt     = uart_tm_en;
      busy_nxt      = tx_busy;
      do_load       = 1'b0;

      if (tx_vld && !hold_full) begin
         hold_nxt      = tx_data;
         hold_full_nxt = 1'b1;
      end

      case (state)
         ST_IDLE: begin
            do_load = hold_full;
         end
         ST_START: begin
            if (uart_tm_ov) begin
               txd_nxt   = shift[0];
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (uart_tm_ov) begin
               parity_nxt  = parity ^ shift[0];
               shift_nxt   = {1'b0, shift[7:1]};
               bit_cnt_nxt = bit_cnt + 3'd1;
               if (bit_cnt == LAST_BIT) begin
                  if (PARITY_EN != 0) begin
                     txd_nxt   = parity_nxt;
                     state_nxt = ST_PARITY;
                  end else begin
                     txd_nxt      = 1'b1;
                     stop_cnt_nxt = 1'b0;
                     state_nxt    = ST_STOP;
                  end
               end else begin
                  txd_nxt = shift[1];
               end
            end
         end
         ST_PARITY: begin
            if (uart_tm_ov) begin
               txd_nxt      = 1'b1;
               stop_cnt_nxt = 1'b0;
               state_nxt    = ST_STOP;
            end
         end
         ST_STOP: begin
            if (uart_tm_ov) begin
               if (stop_cnt != LAST_STOP) begin
                  stop_cnt_nxt = stop_cnt + 1'b1;
               end else if (hold_full) begin
                  // Chain straight into the next frame with the timer still running
                  do_load = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
                  tm_en_nxt = 1'b0;
                  busy_nxt  = 1'b0;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (do_load) begin
         shift_nxt     = hold;
         hold_full_nxt = 1'b0;
         bit_cnt_nxt   = 3'd0;
         parity_nxt    = 1'(PARITY_ODD);
         txd_nxt       = 1'b0;
         tm_en_nxt     = 1'b1;
         busy_nxt      = 1'b1;
         state_nxt     = ST_START;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx with a bit-period timer model
module tb_uart_tx;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] vld, rdy, tm_en, ov, txd, busy, force_ov;
   logic [7:0] data [4];
   logic [7:0] cnt [4];

   int errors = 0;
   int checks = 0;
   bit exp_q[$];

   always #5 clk = ~clk;

   // Timer model: counts while enabled, pulses ov on the last cycle of each period
   for (genvar g = 0; g < 4; g++) begin : g_tmr
      always_ff @(posedge clk) begin
         if (!tm_en[g]) cnt[g] <= 8'd0;
         else if (cnt[g] == 8'(BIT_PERIOD - 1)) cnt[g] <= 8'd0;
         else cnt[g] <= cnt[g] + 8'd1;
      end
      assign ov[g] = (tm_en[g] && cnt[g] == 8'(BIT_PERIOD - 1)) || force_ov[g];
   end

   uart_tx u_8n1 (
      .clk(clk), .rst(rst), .tx_data(data[0]), .tx_vld(vld[0]), .tx_rdy(rdy[0]),
      .uart_tm_en(tm_en[0]), .uart_tm_ov(ov[0]), .txd(txd[0]), .tx_busy(busy[0]));

   uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
      .clk(clk), .rst(rst), .tx_data(data[1]), .tx_vld(vld[1]), .tx_rdy(rdy[1]),
      .uart_tm_en(tm_en[1]), .uart_tm_ov(ov[1]), .txd(txd[1]), .tx_busy(busy[1]));

   uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
      .clk(clk), .rst(rst), .tx_data(data[2]), .tx_vld(vld[2]), .tx_rdy(rdy[2]),
      .uart_tm_en(tm_en[2]), .uart_tm_ov(ov[2]), .txd(txd[2]), .tx_busy(busy[2]));

   uart_tx #(.DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
      .clk(clk), .rst(rst), .tx_data(data[3]), .tx_vld(vld[3]), .tx_rdy(rdy[3]),
      .uart_tm_en(tm_en[3]), .uart_tm_ov(ov[3]), .txd(txd[3]), .tx_busy(busy[3]));

   function automatic void push_frame(input logic [7:0] b, input int db, input int pen,
                                      input int podd, input int sb);
      logic p;
      p = podd[0];
      exp_q.push_back(1'b0);
      for (int k = 0; k < db; k++) begin
         exp_q.push_back(b[k]);
         p ^= b[k];
      end
      if (pen != 0) exp_q.push_back(p);
      for (int k = 0; k < sb; k++) exp_q.push_back(1'b1);
   endfunction

   task automatic send(input int i, input logic [7:0] b);
      bit accepted;
      accepted = 0;
      vld[i]  = 1'b1;
      data[i] = b;
      for (int n = 0; n < 5000 && !accepted; n++) begin
         if (rdy[i] === 1'b1) accepted = 1;
         @(negedge clk);
      end
      vld[i] = 1'b0;
      checks++;
      if (!accepted) begin
         errors++;
         $display("FAIL send_accept inst %0d: byte %02h not accepted within bound", i, b);
      end
   endtask

   task automatic monitor(input int i, input int nbits);
      bit found, e;
      int busy_cnt, drops;
      found = 0;
      busy_cnt = 0;
      drops = 0;
      for (int n = 0; n < 3000; n++) begin
         if (txd[i] === 1'b0) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL start_bit inst %0d: no start bit within bound", i);
         exp_q.delete();
         return;
      end
      for (int b = 0; b < nbits; b++) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
         for (int k = 0; k < BIT_PERIOD; k++) begin
            if (k == 0 || k == BIT_PERIOD - 1) begin
               checks++;
               if (txd[i] !== e) begin
                  errors++;
                  $display("FAIL bit%0d_cyc%0d inst %0d: txd=%b expected %b", b, k, i, txd[i], e);
               end
            end
            if (busy[i] === 1'b1) busy_cnt++;
            if (tm_en[i] !== 1'b1) drops++;
            @(negedge clk);
         end
      end
      checks++;
      if (busy_cnt != nbits * BIT_PERIOD) begin
         errors++;
         $display("FAIL busy_len inst %0d: %0d cycles expected %0d", i, busy_cnt, nbits * BIT_PERIOD);
      end
      checks++;
      if (drops != 0) begin
         errors++;
         $display("FAIL tm_en_cont inst %0d: low for %0d cycles expected 0", i, drops);
      end
      checks++;
      if (busy[i] !== 1'b0 || tm_en[i] !== 1'b0 || txd[i] !== 1'b1) begin
         errors++;
         $display("FAIL frame_end inst %0d: busy=%b tm_en=%b txd=%b expected 0 0 1",
                  i, busy[i], tm_en[i], txd[i]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (txd[i] !== 1'b1 || tm_en[i] !== 1'b0 || busy[i] !== 1'b0 || rdy[i] !== 1'b1) begin
            errors++;
            $display("FAIL reset_state inst %0d: txd=%b tm_en=%b busy=%b rdy=%b expected 1 0 0 1",
                     i, txd[i], tm_en[i], busy[i], rdy[i]);
         end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_8n1();
      push_frame(8'h55, 8, 0, 0, 1);
      send(0, 8'h55);
      monitor(0, 10);
   endtask

   task automatic test_back_to_back();
      push_frame(8'hA3, 8, 0, 0, 1);
      push_frame(8'h0F, 8, 0, 0, 1);
      send(0, 8'hA3);
      checks++;
      if (rdy[0] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_rdy_full: tx_rdy=%b expected 0", rdy[0]);
      end
      fork
         send(0, 8'h0F);
         monitor(0, 20);
      join
   endtask

   task automatic test_parity();
      push_frame(8'h07, 8, 1, 0, 1);
      send(1, 8'h07);
      monitor(1, 11);
      push_frame(8'h07, 8, 1, 1, 1);
      send(2, 8'h07);
      monitor(2, 11);
   endtask

   task automatic test_stop2();
      push_frame(8'h41, 7, 0, 0, 2);
      send(3, 8'h41);
      monitor(3, 10);
   endtask

   task automatic test_reset_mid_frame();
      int bad;
      bad = 0;
      exp_q.delete();
      send(0, 8'h00);
      send(0, 8'h55);
      // Two negedges after the first send; land mid data bit 3 (period 4)
      repeat (4 * BIT_PERIOD + 100 - 1) @(negedge clk);
      checks++;
      if (txd[0] !== 1'b0 || busy[0] !== 1'b1 || rdy[0] !== 1'b0) begin
         errors++;
         $display("FAIL mid_frame_pre: txd=%b busy=%b rdy=%b expected 0 1 0", txd[0], busy[0], rdy[0]);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (txd[0] !== 1'b1 || tm_en[0] !== 1'b0 || rdy[0] !== 1'b1 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL mid_frame_reset: txd=%b tm_en=%b rdy=%b busy=%b expected 1 0 1 0",
                  txd[0], tm_en[0], rdy[0], busy[0]);
      end
      repeat (3000) begin
         @(negedge clk);
         if (txd[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL discarded_byte: line active for %0d cycles expected 0", bad);
      end
   endtask

   task automatic test_idle_ov();
      for (int p = 0; p < 8; p++) begin
         force_ov[0] = 1'b1;
         @(negedge clk);
         force_ov[0] = 1'b0;
         @(negedge clk);
         checks++;
         if (txd[0] !== 1'b1 || busy[0] !== 1'b0 || tm_en[0] !== 1'b0) begin
            errors++;
            $display("FAIL idle_ov pulse %0d: txd=%b busy=%b tm_en=%b expected 1 0 0",
                     p, txd[0], busy[0], tm_en[0]);
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      vld      = 4'b0;
      force_ov = 4'b0;
      for (int i = 0; i < 4; i++) data[i] = 8'h00;
      test_reset();
      test_8n1();
      test_back_to_back();
      test_parity();
      test_stop2();
      test_reset_mid_frame();
      test_idle_ov();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
